register_file_mp: RTL

Parametrised successor to the CPU register file: two registered read ports, one write port with byte-lane enables, write-first bypass, and a hardwired-zero register. After reset or a software clear request, a sequential clear engine zeroes the array one entry per cycle, so no wide reset fan-out is needed. Sits in the decode/writeback stage of the CPU. Uses big-endian bit numbering throughout: bit 0 is the MSB, and byte lane 0 is bits [0:7].

---
 rtl/register_file_mp.sv | 138 +++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port CPU register file: two registered read ports, one byte-lane write port,
// optional write-first bypass and hardwired zero entry, with a one-entry-per-cycle clear engine.
module register_file_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  o_dbg_state,
   input  logic                  rA_en,
   input  logic [ADDR_W-1:0]     rA_address,
   output logic [0:DATA_W-1]     rA_data,
   input  logic                  rB_en,
   input  logic [ADDR_W-1:0]     rB_address,
   output logic [0:DATA_W-1]     rB_data,
   input  logic                  writeEnable,
   input  logic [ADDR_W-1:0]     rD_address,
   input  logic [0:DATA_W/8-1]   rD_byte_en,
   input  logic [0:DATA_W-1]     rD_data,
   output logic                  wr_err
);

   localparam int                NB       = DATA_W / 8;
   localparam logic [ADDR_W:0]   NUM_W    = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_idx, w_clr_idx_nxt;
   logic [0:DATA_W-1]   r_mem [NUM_REGS];

   logic                w_idle;
   logic                w_wr_in_range;
   logic                w_wr_legal;
   logic                w_wr_err_nxt;
   logic [0:DATA_W-1]   w_old;
   logic [0:DATA_W-1]   w_merged;
   logic [0:DATA_W-1]   w_rA_val;
   logic [0:DATA_W-1]   w_rB_val;

   function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < NUM_W;
   endfunction

   function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt   = ST_IDLE;
               w_clr_idx_nxt = '0;
            end else begin
               w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (clear_req) w_state_nxt = ST_CLEAR;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy        = (r_state == ST_CLEAR);
   assign o_dbg_state = r_state;
   assign w_idle      = (r_state == ST_IDLE);

   // A write with no lanes enabled is a no-op, so it never flags an out-of-range address.
   assign w_wr_in_range = f_in_range(rD_address);
   assign w_wr_legal    = w_idle && writeEnable && w_wr_in_range && !f_is_zero(rD_address);
   assign w_wr_err_nxt  = writeEnable && (!w_idle || (!w_wr_in_range && (|rD_byte_en)));
   assign w_old         = w_wr_in_range ? r_mem[rD_address] : '0;

   always_comb begin
      w_merged = w_old;
      for (int i = 0; i < NB; i++) begin
         if (rD_byte_en[i]) w_merged[8*i +: 8] = rD_data[8*i +: 8];
      end
   end

   // Zero-register and range rules sit outside the bypass mux so they win over forwarding.
   always_comb begin
      w_rA_val = '0;
      if (w_idle && f_in_range(rA_address) && !f_is_zero(rA_address)) begin
         w_rA_val = (BYPASS != 0 && w_wr_legal && rA_address == rD_address) ? w_merged
                                                                            : r_mem[rA_address];
      end
   end

   always_comb begin
      w_rB_val = '0;
      if (w_idle && f_in_range(rB_address) && !f_is_zero(rB_address)) begin
         w_rB_val = (BYPASS != 0 && w_wr_legal && rB_address == rD_address) ? w_merged
                                                                            : r_mem[rB_address];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rA_data <= '0;
         rB_data <= '0;
         wr_err  <= 1'b0;
      end else begin
         if (rA_en) rA_data <= w_rA_val;
         if (rB_en) rB_data <= w_rB_val;
         wr_err <= w_wr_err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!w_idle) begin
         r_mem[r_clr_idx] <= '0;
      end else if (w_wr_legal) begin
         r_mem[rD_address] <= w_merged;
      end
   end

endmodule
